died_overlay_reader: RTL and testbench

Read-side consumer of the game-over bitmap ROM (30 rows x 40 bits, row-addressed, combinational read, bit 39 = leftmost column). It converts VGA draw coordinates into ROM row addresses, extracts the addressed bit, and produces a pipelined pixel-on flag for the colour mapper. It also sequences the overlay's appearance: a top-down row-by-row reveal once game_over asserts, then a frame-counted blink, frozen or cleared by game state.

---
 rtl/overlay_pkg.sv | 9 +
 rtl/overlay_seq.sv | 93 +++++++++
 rtl/died_overlay_reader.sv | 55 +++++
 tb/tb_died_overlay_reader.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// Shared types and geometry for game-over bitmap ROM readers.
package overlay_pkg;
    typedef enum logic [1:0] {IDLE, REVEAL, BLINK} overlay_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BMP_ROWS = 30;
    localparam int BMP_COLS = 40;
endpackage

// File: rtl/overlay_seq.sv
// Overlay appearance sequencer: top-down row reveal, then frame-counted blink.
module overlay_seq
    import overlay_pkg::*;
#(
    parameter int ROWS          = BMP_ROWS,
    parameter int REVEAL_FRAMES = 2,
    parameter int BLINK_FRAMES  = 30,
    parameter int RR_W          = $clog2(ROWS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            game_over,
    output logic [RR_W-1:0] reveal_rows,
    output logic            show,
    output logic            overlay_active
);
    localparam int FC_MAX = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
    localparam int FC_W   = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;

    overlay_state_t  state, state_n;
    logic [RR_W-1:0] rr_n;
    logic [FC_W-1:0] frame_cnt, fc_n;
    logic            blink_phase, bp_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            reveal_rows    <= '0;
            frame_cnt      <= '0;
            blink_phase    <= 1'b1;
            overlay_active <= 1'b0;
        end else begin
            state          <= state_n;
            reveal_rows    <= rr_n;
            frame_cnt      <= fc_n;
            blink_phase    <= bp_n;
            overlay_active <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        rr_n    = reveal_rows;
        fc_n    = frame_cnt;
        bp_n    = blink_phase;
        // Dropping game_over wins over any coincident frame_start.
        if (!game_over) begin
            state_n = IDLE;
            rr_n    = '0;
            fc_n    = '0;
            bp_n    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_n = REVEAL;
                    rr_n    = '0;
                    fc_n    = '0;
                end
                REVEAL: if (frame_start) begin
                    if (frame_cnt == FC_W'(REVEAL_FRAMES - 1)) begin
                        fc_n = '0;
                        if (reveal_rows < RR_W'(ROWS)) rr_n = reveal_rows + 1'b1;
                        if (reveal_rows >= RR_W'(ROWS - 1)) begin
                            state_n = BLINK;
                            bp_n    = 1'b1;
                        end
                    end else begin
                        fc_n = frame_cnt + 1'b1;
                    end
                end
                BLINK: if (frame_start) begin
                    if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                        fc_n = '0;
                        bp_n = ~blink_phase;
                    end else begin
                        fc_n = frame_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        show = 1'b0;
        case (state)
            REVEAL:  show = 1'b1;
            BLINK:   show = blink_phase;
            default: show = 1'b0;
        endcase
    end
endmodule

// File: rtl/died_overlay_reader.sv
// Game-over overlay reader: coordinate-to-ROM pipeline plus reveal/blink gating.
module died_overlay_reader
    import overlay_pkg::*;
#(
    parameter int ROWS          = BMP_ROWS,
    parameter int COLS          = BMP_COLS,
    parameter int SCALE_SHIFT   = 4,
    parameter int REVEAL_FRAMES = 2,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_start,
    input  logic            game_over,
    input  logic [9:0]      DrawX,
    input  logic [9:0]      DrawY,
    input  logic [COLS-1:0] rom_data,
    output logic [5:0]      rom_addr,
    output logic            pixel_on,
    output logic            overlay_active
);
    localparam int RR_W = $clog2(ROWS + 1);

    logic [RR_W-1:0] reveal_rows;
    logic            show;
    logic            in_range, in_range_q;
    logic [5:0]      row, col, col_q, bit_idx;

    overlay_seq #(
        .ROWS(ROWS), .REVEAL_FRAMES(REVEAL_FRAMES), .BLINK_FRAMES(BLINK_FRAMES), .RR_W(RR_W)
    ) u_seq (
        .clk(Clk), .rst(Reset), .frame_start(frame_start), .game_over(game_over),
        .reveal_rows(reveal_rows), .show(show), .overlay_active(overlay_active)
    );

    assign in_range = (DrawX < 10'(COLS << SCALE_SHIFT)) && (DrawY < 10'(ROWS << SCALE_SHIFT));
    assign row      = 6'(DrawY >> SCALE_SHIFT);
    assign col      = 6'(DrawX >> SCALE_SHIFT);
    // Out-of-range zeroes col_q too, so the bit select below never leaves the word.
    assign bit_idx  = 6'(COLS - 1) - col_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr   <= '0;
            col_q      <= '0;
            in_range_q <= 1'b0;
            pixel_on   <= 1'b0;
        end else begin
            rom_addr   <= in_range ? row : 6'd0;
            col_q      <= in_range ? col : 6'd0;
            in_range_q <= in_range;
            pixel_on   <= in_range_q & rom_data[bit_idx] & (rom_addr < 6'(reveal_rows)) & show;
        end
    end
endmodule

// File: tb/tb_died_overlay_reader.sv
// Randomized + directed bench for died_overlay_reader against a frame-count reference model.
module tb_died_overlay_reader;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        game_over = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic [39:0] rom_data;
    logic [5:0]  rom_addr;
    logic        pixel_on, overlay_active;

    logic [39:0] rom [0:29];
    int          checks = 0, failures = 0;

    // Reference model: overlay active flag and frame_starts counted since entry.
    bit          m_active = 0;
    int          m_frames = 0;
    logic [9:0]  px = '0, py = '0;
    bit          pvalid = 0;
    bit          cur_go = 0;
    logic [5:0]  a_obs;
    logic        p_obs;

    died_overlay_reader dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .game_over(game_over),
        .DrawX(DrawX), .DrawY(DrawY), .rom_data(rom_data), .rom_addr(rom_addr),
        .pixel_on(pixel_on), .overlay_active(overlay_active)
    );

    always #5 Clk = ~Clk;

    always_comb rom_data = (rom_addr < 6'd30) ? rom[rom_addr] : 40'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_screen(input logic [9:0] x, input logic [9:0] y);
        return (x < 10'd640) && (y < 10'd480);
    endfunction

    function automatic bit model_pixel(input logic [9:0] x, input logic [9:0] y, input bit valid);
        int rr, r, c;
        bit shw;
        if (!valid || !in_screen(x, y) || !m_active) return 0;
        rr  = (m_frames / 2 > 30) ? 30 : m_frames / 2;
        shw = (m_frames >= 60) ? (((m_frames - 60) / 30) % 2 == 0) : 1'b1;
        r   = int'(y) / 16;
        c   = int'(x) / 16;
        return rom[r][39 - c] && (r < rr) && shw;
    endfunction

    task automatic tick(input bit fs, input bit go, input logic [9:0] x, input logic [9:0] y);
        logic [5:0] e_addr;
        bit         e_pix;
        @(negedge Clk);
        frame_start = fs; game_over = go; DrawX = x; DrawY = y; cur_go = go;
        @(posedge Clk);
        e_pix  = model_pixel(px, py, pvalid);
        e_addr = in_screen(x, y) ? 6'(int'(y) / 16) : 6'd0;
        if (!go) begin
            m_active = 0; m_frames = 0;
        end else if (!m_active) begin
            m_active = 1; m_frames = 0;
        end else if (fs) begin
            m_frames++;
        end
        px = x; py = y; pvalid = 1;
        #1;
        chk("rom_addr", 32'(rom_addr), 32'(e_addr));
        chk("pixel_on", 32'(pixel_on), 32'(e_pix));
        chk("overlay_active", 32'(overlay_active), 32'(m_active));
    endtask

    task automatic rtick(input bit fs, input bit go);
        tick(fs, go, 10'($urandom_range(0, 719)), 10'($urandom_range(0, 539)));
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y);
        tick(0, cur_go, x, y);
        a_obs = rom_addr;
        tick(0, cur_go, x, y);
        p_obs = pixel_on;
    endtask

    initial begin
        for (int i = 0; i < 30; i++) rom[i] = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
        rom[11][39-8] = 1'b1;
        rom[11][39-7] = 1'b0;
        rom[24][39-5] = 1'b1;
        rom[0][39]    = 1'b1;

        #3;
        chk("reset_pixel_on", 32'(pixel_on), 0);
        chk("reset_rom_addr", 32'(rom_addr), 0);
        chk("reset_active", 32'(overlay_active), 0);
        @(negedge Clk); Reset = 1'b0;
        tick(0, 0, 10'd128, 10'd176);

        // Reveal: entry cycle's frame_start is ignored, then 22 frames -> 11 rows.
        tick(1, 1, 10'd0, 10'd0);
        for (int i = 0; i < 22; i++) rtick(1, 1);
        probe(10'd128, 10'd176);
        chk("reveal22_addr", 32'(a_obs), 11);
        chk("reveal22_row11_dark", 32'(p_obs), 0);
        rtick(1, 1); rtick(1, 1);
        probe(10'd128, 10'd176);
        chk("reveal24_row11_lit", 32'(p_obs), 1);
        for (int i = 0; i < 40; i++) rtick($urandom_range(0, 3) == 0, 1);
        while (m_frames < 60) rtick(1, 1);

        // Blink phase 1 on entry.
        probe(10'd128, 10'd176);
        chk("blink_row11_addr", 32'(a_obs), 11);
        chk("blink_row11_col8", 32'(p_obs), 1);
        probe(10'd112, 10'd176);
        chk("blink_row11_col7", 32'(p_obs), 0);
        probe(10'd80, 10'd384);
        chk("blink_f0_on", 32'(p_obs), 1);
        for (int i = 0; i < 29; i++) rtick(1, 1);
        probe(10'd80, 10'd384);
        chk("blink_f29_on", 32'(p_obs), 1);
        rtick(1, 1);
        probe(10'd80, 10'd384);
        chk("blink_f30_off", 32'(p_obs), 0);
        for (int i = 0; i < 29; i++) rtick(1, 1);
        probe(10'd80, 10'd384);
        chk("blink_f59_off", 32'(p_obs), 0);
        rtick(1, 1);
        probe(10'd80, 10'd384);
        chk("blink_f60_on", 32'(p_obs), 1);

        // Off-screen coordinates with the whole bitmap visible.
        probe(10'd700, 10'd176);
        chk("oor_x_addr", 32'(a_obs), 0);
        chk("oor_x_pix", 32'(p_obs), 0);
        probe(10'd128, 10'd500);
        chk("oor_y_addr", 32'(a_obs), 0);
        chk("oor_y_pix", 32'(p_obs), 0);
        probe(10'd639, 10'd479);
        chk("corner_addr", 32'(a_obs), 29);

        for (int i = 0; i < 150; i++) rtick($urandom_range(0, 7) == 0, 1);

        // Asynchronous reset in the middle of BLINK.
        @(negedge Clk); #2 Reset = 1'b1;
        #1;
        chk("midblink_rst_pixel", 32'(pixel_on), 0);
        chk("midblink_rst_active", 32'(overlay_active), 0);
        chk("midblink_rst_addr", 32'(rom_addr), 0);
        @(negedge Clk); game_over = 1'b0; Reset = 1'b0;
        m_active = 0; m_frames = 0; pvalid = 0;
        tick(0, 0, 10'd0, 10'd0);
        chk("after_rst_idle", 32'(overlay_active), 0);

        // Drop game_over together with frame_start mid-reveal, then restart.
        tick(0, 1, 10'd0, 10'd0);
        for (int i = 0; i < 5; i++) rtick(1, 1);
        rtick(1, 0);
        chk("drop_active", 32'(overlay_active), 0);
        tick(1, 1, 10'd0, 10'd0);
        probe(10'd0, 10'd0);
        chk("restart_row0_dark", 32'(p_obs), 0);
        rtick(1, 1); rtick(1, 1);
        probe(10'd0, 10'd0);
        chk("restart_row0_lit", 32'(p_obs), 1);

        for (int i = 0; i < 400; i++) rtick($urandom_range(0, 2) == 0, $urandom_range(0, 59) != 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
